click_req_src: RTL

Upstream request source for the single-click handshake pipeline. It debounces a raw push-button and, once per clean press, launches one two-phase request toggle on the click element's input request (`in_R`). It then waits for the matching acknowledge toggle (`in_A`) and counts completed transactions. It also flags acknowledges that arrive late or spontaneously, so the board shows the handshake state alongside the ROM/7-segment output.

---
 rtl/click_req_src.sv | 132 +++++++++++++
 1 files changed

// File: rtl/click_req_src.sv
// Debounced push-button request source for a two-phase click handshake.
// Issues one request toggle per clean press, tracks the acknowledge and flags late or stray acks.
module click_req_src #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    input  logic             ack_in,
    input  logic             clr_err,
    output logic             req_out,
    output logic             busy,
    output logic             timeout_err,
    output logic             proto_err,
    output logic [CNT_W-1:0] req_cnt
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TM_W = $clog2(TIMEOUT_CYCLES);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    logic btn_m, btn_s, ack_m, ack_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
            ack_m <= ack_in;
            ack_s <= ack_m;
        end
    end

    logic            btn_db, btn_db_prev;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    // Counter value DEBOUNCE_CYCLES-2 means this edge is the one where it would reach the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db      <= 1'b0;
            btn_db_prev <= 1'b0;
            db_cnt      <= '0;
        end else begin
            btn_db_prev <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 2)) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = btn_db & ~btn_db_prev;

    logic             state_q, state_d;
    logic             req_q, req_d;
    logic [TM_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d, terr_set;
    logic             perr_q, perr_d, perr_set;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        terr_set = 1'b0;
        perr_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A stray ack is flagged but not realigned; only a press restores equality.
                if (ack_s != req_q) begin
                    perr_set = 1'b1;
                end
                if (press) begin
                    req_d   = ~req_q;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack_s == req_q) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == TM_W'(TIMEOUT_CYCLES - 1)) begin
                    terr_set = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase
        terr_d = terr_set | (terr_q & ~clr_err);
        perr_d = perr_set | (perr_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            timer_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            perr_q  <= perr_d;
        end
    end

    assign req_out     = req_q;
    assign busy        = (state_q == ST_WAIT);
    assign timeout_err = terr_q;
    assign proto_err   = perr_q;
    assign req_cnt     = cnt_q;

endmodule
